// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM burst stream reader.
// The read latency selects between an unregistered and a registered RAM output.
package ram_stream_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rsr_state_t;

    localparam int RSR_LAT_UNREG = 1;
    localparam int RSR_LAT_REG   = 2;

    function automatic bit rsr_latency_ok(int lat);
        return (lat == RSR_LAT_UNREG) || (lat == RSR_LAT_REG);
    endfunction

endpackage

// File: rtl/ram_stream_fifo.sv
// Small synchronous skid FIFO holding {last, data} beats between the RAM and the stream port.
// The head is driven from storage registers, so nothing on the write side reaches it combinationally.
module ram_stream_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock0,
    input  logic             sclr_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is cleared on reset so the stream data reads as zero afterwards.
    always_ff @(posedge clock0) begin
        if (!sclr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader behind a single-clock RAM read port: issues one read per cycle under a
// FIFO credit limit, absorbs the RAM read latency and streams the words out with a last flag.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock0,
    input  logic                  sclr_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_adr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_rden,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int OUT_W  = $clog2(RD_LATENCY + 1) + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CRED_W = ((OUT_W > CNT_W) ? OUT_W : CNT_W) + 1;

    if (!rsr_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("ram_stream_reader: RD_LATENCY must be 1 or 2");
    end
    if ((FIFO_DEPTH < RD_LATENCY + 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ram_stream_reader: FIFO_DEPTH must be a power of 2 and at least RD_LATENCY+1");
    end

    rsr_state_t              state;
    logic [ADDR_WIDTH-1:0]   next_adr;
    logic [LEN_WIDTH-1:0]    remaining;
    logic [LEN_WIDTH-1:0]    rem_after;
    logic [RD_LATENCY-1:0]   pipe_valid;
    logic [RD_LATENCY-1:0]   pipe_last;
    logic [OUT_W-1:0]        outstanding;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic [DATA_WIDTH:0]     head;
    logic                    push;
    logic                    pop;
    logic                    issue_last;
    logic [CRED_W-1:0]       credits_next;

    // Credits for the next cycle: FIFO entries plus reads in flight once this cycle's issue and pop land.
    always_comb begin
        push         = pipe_valid[RD_LATENCY-1];
        pop          = m_valid & m_ready;
        issue_last   = ram_rden && (remaining == LEN_WIDTH'(1));
        rem_after    = remaining - LEN_WIDTH'(ram_rden);
        credits_next = CRED_W'(fifo_count) + CRED_W'(outstanding) + CRED_W'(ram_rden) - CRED_W'(pop);
    end

    always_ff @(posedge clock0) begin
        if (!sclr_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_rden    <= 1'b0;
            ram_address <= '0;
            next_adr    <= '0;
            remaining   <= '0;
            pipe_valid  <= '0;
            pipe_last   <= '0;
            outstanding <= '0;
        end else begin
            done        <= 1'b0;
            ram_rden    <= 1'b0;
            pipe_valid  <= RD_LATENCY'({pipe_valid, ram_rden});
            pipe_last   <= RD_LATENCY'({pipe_last, issue_last});
            outstanding <= outstanding + OUT_W'(ram_rden) - OUT_W'(push);
            remaining   <= rem_after;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (length != '0) begin
                            state       <= ISSUE;
                            ram_rden    <= 1'b1;
                            ram_address <= base_adr;
                            next_adr    <= base_adr + ADDR_WIDTH'(1);
                            remaining   <= length;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_last) begin
                        state <= DRAIN;
                    end else if ((rem_after != '0) && (credits_next < CRED_W'(FIFO_DEPTH))) begin
                        ram_rden    <= 1'b1;
                        ram_address <= next_adr;
                        next_adr    <= next_adr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (pop && head[DATA_WIDTH]) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ram_stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock0    (clock0),
        .sclr_n    (sclr_n),
        .push      (push),
        .push_data ({pipe_last[RD_LATENCY-1], ram_q}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign m_valid = ~fifo_empty;
    assign m_data  = head[DATA_WIDTH-1:0];
    assign m_last  = head[DATA_WIDTH];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Drives an unregistered-RAM reader and a registered-RAM reader side by side with the same bursts,
// checking every beat, address and handshake against a burst-level model.
module tb_ram_stream_reader;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int LW    = 11;
    localparam int DEPTH = 4;

    logic          clock0 = 1'b0;
    logic          sclr_n;
    logic          start;
    logic          m_ready;
    logic [AW-1:0] base_adr;
    logic [LW-1:0] length;
    logic [1:0]    busy_a;
    logic [1:0]    done_a;
    logic [1:0]    rden_a;
    logic [1:0]    m_valid_a;
    logic [1:0]    m_last_a;
    logic [AW-1:0] adr_a [2];
    logic [DW-1:0] m_data_a [2];
    logic [DW-1:0] mem [1024];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_pct = 100;
    int cur_base, cur_len, start_cyc;
    int beat_idx [2];
    int issue_idx [2];
    int done_cnt [2];
    int done_cyc [2];
    int busy_cnt [2];
    int first_valid [2];
    int first_beat [2];
    int last_beat [2];
    int peak [2];
    logic prev_stall [2];
    logic [DW:0] prev_head [2];

    always #5 clock0 = ~clock0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] q1;
        logic [DW-1:0] q2;
        logic [DW-1:0] ram_q;

        // RAM model: address registered with rden; instance 1 adds an output register.
        always @(posedge clock0) begin
            if (rden_a[g]) q1 <= mem[adr_a[g]];
            q2 <= q1;
        end
        assign ram_q = (g == 0) ? q1 : q2;

        ram_stream_reader #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .LEN_WIDTH  (LW),
            .RD_LATENCY (g + 1),
            .FIFO_DEPTH (DEPTH)
        ) dut (
            .clock0      (clock0),
            .sclr_n      (sclr_n),
            .start       (start),
            .base_adr    (base_adr),
            .length      (length),
            .busy        (busy_a[g]),
            .done        (done_a[g]),
            .ram_address (adr_a[g]),
            .ram_rden    (rden_a[g]),
            .ram_q       (ram_q),
            .m_valid     (m_valid_a[g]),
            .m_ready     (m_ready),
            .m_data      (m_data_a[g]),
            .m_last      (m_last_a[g])
        );
    end

    function automatic logic [DW-1:0] expWord(int adr);
        return DW'(adr % 1024) ^ 32'hA5A5_0000;
    endfunction

    task automatic checkOutput(string tag, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < 2; k++) begin
            beat_idx[k]    = 0;
            issue_idx[k]   = 0;
            done_cnt[k]    = 0;
            done_cyc[k]    = -1;
            busy_cnt[k]    = 0;
            first_valid[k] = -1;
            first_beat[k]  = -1;
            last_beat[k]   = -1;
            peak[k]        = 0;
        end
    endtask

    // Per-cycle monitor for one instance; outputs are stable at the falling edge.
    task automatic observe(int k);
        int infl;
        if (rden_a[k]) begin
            infl = issue_idx[k] - beat_idx[k] + 1;
            if (infl > peak[k]) peak[k] = infl;
            if (issue_idx[k] < cur_len)
                checkOutput($sformatf("L%0d ram_address #%0d", k + 1, issue_idx[k]),
                            64'(adr_a[k]), 64'((cur_base + issue_idx[k]) % 1024));
            else
                checkOutput($sformatf("L%0d extra ram_rden", k + 1), 1, 0);
            issue_idx[k]++;
        end
        if (prev_stall[k])
            checkOutput($sformatf("L%0d hold under backpressure", k + 1),
                        {m_valid_a[k], m_last_a[k], m_data_a[k]}, {1'b1, prev_head[k]});
        if (m_valid_a[k] && first_valid[k] < 0) first_valid[k] = cyc;
        if (m_valid_a[k] && m_ready) begin
            if (beat_idx[k] < cur_len)
                checkOutput($sformatf("L%0d beat #%0d", k + 1, beat_idx[k]),
                            {m_last_a[k], m_data_a[k]},
                            {beat_idx[k] == cur_len - 1, expWord(cur_base + beat_idx[k])});
            else
                checkOutput($sformatf("L%0d extra beat", k + 1), 1, 0);
            if (first_beat[k] < 0) first_beat[k] = cyc;
            last_beat[k] = cyc;
            beat_idx[k]++;
        end
        if (busy_a[k]) busy_cnt[k]++;
        if (done_a[k]) begin
            done_cnt[k]++;
            done_cyc[k] = cyc;
        end
        prev_stall[k] = m_valid_a[k] && !m_ready;
        prev_head[k]  = {m_last_a[k], m_data_a[k]};
    endtask

    task automatic tick();
        @(negedge clock0);
        if (sclr_n) begin
            observe(0);
            observe(1);
        end else begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end
        cyc++;
        @(posedge clock0);
        #1;
        m_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic checkIdleOutputs(string tag);
        checkOutput({tag, " busy"}, 64'(busy_a), 0);
        checkOutput({tag, " done"}, 64'(done_a), 0);
        checkOutput({tag, " ram_rden"}, 64'(rden_a), 0);
        checkOutput({tag, " m_valid"}, 64'(m_valid_a), 0);
        checkOutput({tag, " m_last"}, 64'(m_last_a), 0);
        checkOutput({tag, " m_data"}, {m_data_a[1], m_data_a[0]}, 0);
        checkOutput({tag, " ram_address"}, {adr_a[1], adr_a[0]}, 0);
    endtask

    // One burst on both instances; glitch pulses a second start while they are busy.
    task automatic applyStimulus(int base, int len, int pct, bit glitch);
        int n;
        int budget;
        ready_pct = pct;
        m_ready   = ($urandom_range(0, 99) < ready_pct);
        cur_base  = base;
        cur_len   = len;
        clearModel();
        start_cyc = cyc;
        start     = 1'b1;
        base_adr  = AW'(base);
        length    = LW'(len);
        tick();
        start  = 1'b0;
        budget = 40 * len + 60;
        n      = 0;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < budget) begin
            if (glitch && n == 1) begin
                start    = 1'b1;
                base_adr = 10'h200;
                length   = 11'd5;
            end
            tick();
            start = 1'b0;
            n++;
        end
        if (n >= budget) checkOutput($sformatf("burst base=%0h len=%0d timeout", base, len), 1, 0);
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("L%0d beat count", k + 1), beat_idx[k], len);
            checkOutput($sformatf("L%0d read count", k + 1), issue_idx[k], len);
            checkOutput($sformatf("L%0d done pulses", k + 1), done_cnt[k], 1);
            checkOutput($sformatf("L%0d busy cycles", k + 1), busy_cnt[k], done_cyc[k] - start_cyc);
            checkOutput($sformatf("L%0d done timing", k + 1), done_cyc[k],
                        (len == 0) ? start_cyc + 1 : last_beat[k] + 1);
            checkOutput($sformatf("L%0d credit limit", k + 1), peak[k] <= DEPTH, 1);
            if (len == 0)
                checkOutput($sformatf("L%0d no m_valid", k + 1), first_valid[k], -1);
            else if (pct == 100) begin
                checkOutput($sformatf("L%0d first beat latency", k + 1), first_valid[k] - start_cyc, k + 3);
                checkOutput($sformatf("L%0d back-to-back", k + 1), last_beat[k] - first_beat[k], len - 1);
            end
        end
    endtask

    task automatic resetMidBurst();
        ready_pct = 0;
        m_ready   = 1'b0;
        cur_base  = 'h40;
        cur_len   = 16;
        clearModel();
        start     = 1'b1;
        base_adr  = 10'h040;
        length    = 11'd16;
        tick();
        start = 1'b0;
        repeat (10) tick();
        checkOutput("stalled FIFO holds data", 64'(m_valid_a), 3);
        checkOutput("stalled reads bounded", {32'(issue_idx[1]), 32'(issue_idx[0])}, {32'(DEPTH), 32'(DEPTH)});
        sclr_n = 1'b0;
        tick();
        sclr_n = 1'b1;
        checkIdleOutputs("mid-burst reset");
        clearModel();
        cur_len   = 0;
        ready_pct = 100;
        repeat (6) tick();
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("L%0d no done after reset", k + 1), done_cnt[k], 0);
            checkOutput($sformatf("L%0d no m_valid after reset", k + 1), first_valid[k], -1);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i) ^ 32'hA5A5_0000;
        sclr_n   = 1'b0;
        start    = 1'b0;
        base_adr = '0;
        length   = '0;
        m_ready  = 1'b1;
        prev_stall[0] = 1'b0;
        prev_stall[1] = 1'b0;
        cur_len = 0;
        cur_base = 0;
        clearModel();
        repeat (3) tick();
        sclr_n = 1'b1;
        checkIdleOutputs("reset");

        $display("[TB] burst 0x010 x8, ready held high");
        applyStimulus('h010, 8, 100, 1'b0);
        $display("[TB] burst 0x100 x16, ready 30%%");
        applyStimulus('h100, 16, 30, 1'b0);
        $display("[TB] burst across address wrap");
        applyStimulus('h3FE, 4, 100, 1'b0);
        $display("[TB] zero-length burst, then start while busy");
        applyStimulus('h055, 0, 100, 1'b0);
        applyStimulus('h020, 8, 100, 1'b1);
        $display("[TB] reset in the middle of a stalled burst");
        resetMidBurst();
        applyStimulus('h080, 12, 100, 1'b0);
        $display("[TB] random bursts");
        repeat (6) begin
            applyStimulus($urandom_range(0, 1023), $urandom_range(1, 24), $urandom_range(20, 100), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
